// File: rtl/router_pkg.sv
// Shared router definitions: reader FSM states, header field positions and packet limits.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  localparam int HDR_LEN_MSB        = 7;
  localparam int HDR_LEN_LSB        = 2;
  localparam int MAX_PKT_BYTES      = 65;
  localparam int SOFT_RESET_TIMEOUT = 30;

endpackage

// File: rtl/router_parity_acc.sv
// 8-bit running XOR: clear, load a seed byte, or fold in a new byte each cycle.
module router_parity_acc (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       acc_i,
  input  logic [7:0] dat_i,
  output logic [7:0] par_o
);

  logic [7:0] par_q;

  always_ff @(posedge clock) begin
    if (!resetn || clr_i) begin
      par_q <= 8'h00;
    end else if (load_i) begin
      par_q <= dat_i;
    end else if (acc_i) begin
      par_q <= par_q ^ dat_i;
    end
  end

  assign par_o = par_q;

endmodule

// File: rtl/router_dest_reader.sv
// Router destination reader: pulls one packet per visit from the output FIFO and reports its results.
// Parity checking is built only with ROUTER_READER_PARITY_CHECK_EN defined.
module router_dest_reader
  import router_pkg::*;
#(
  parameter int unsigned START_DELAY = 0,
  parameter logic [1:0]  PORT_ADDR   = 2'b00
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  input  logic        soft_reset,
  input  logic        stall_i,
  output logic        read_enb,
  output logic        pkt_done_o,
  output logic [5:0]  pkt_len_o,
  output logic [1:0]  pkt_addr_o,
  output logic        parity_err_o,
  output logic        addr_err_o,
  output logic        abort_o,
  output logic [15:0] pkt_cnt_o
);

  rd_state_e   state_q, state_d;
  logic [4:0]  dly_q, dly_d;
  logic [6:0]  issued_q, issued_d;
  logic [6:0]  cap_q, cap_d;
  logic [6:0]  last_idx, limit;
  logic        rd_q, abort_q, abort_ev, cap_hdr, cap_last, to_idle;
  logic [5:0]  len_q, pkt_len_q;
  logic [1:0]  addr_q, pkt_addr_q;
  logic        addr_err_q;
  logic [15:0] pkt_cnt_q;

  // Until the header lands only header+next byte may be requested; len is unknown.
  assign last_idx = {1'b0, len_q} + 7'd1;
  assign limit    = (cap_q == 7'd0) ? 7'd2 : last_idx + 7'd1;
  assign abort_ev = soft_reset & ((state_q == WAIT) | (state_q == READ));
  assign cap_hdr  = rd_q & (cap_q == 7'd0);
  assign cap_last = rd_q & (cap_q == last_idx);
  assign read_enb = resetn & (state_q == READ) & vld_out & ~stall_i & ~soft_reset
                  & (issued_q < limit);

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    issued_d = issued_q + {6'd0, read_enb};
    cap_d    = cap_q + {6'd0, rd_q};
    case (state_q)
      IDLE: if (vld_out) begin
        state_d = WAIT;
        dly_d   = 5'(START_DELAY);
      end
      WAIT: begin
        if (dly_q == 5'd0) state_d = READ;
        else               dly_d   = dly_q - 5'd1;
      end
      READ: if (cap_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_ev) state_d = IDLE;
    if (state_d == IDLE) begin
      issued_d = 7'd0;
      cap_d    = 7'd0;
      dly_d    = 5'd0;
    end
  end

  assign to_idle = (state_d == IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      dly_q      <= 5'd0;
      issued_q   <= 7'd0;
      cap_q      <= 7'd0;
      rd_q       <= 1'b0;
      abort_q    <= 1'b0;
      len_q      <= 6'd0;
      addr_q     <= 2'd0;
      pkt_len_q  <= 6'd0;
      pkt_addr_q <= 2'd0;
      addr_err_q <= 1'b0;
      pkt_cnt_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      issued_q <= issued_d;
      cap_q    <= cap_d;
      rd_q     <= read_enb;
      abort_q  <= abort_ev;
      if (cap_hdr) begin
        len_q  <= data_out[HDR_LEN_MSB:HDR_LEN_LSB];
        addr_q <= data_out[HDR_LEN_LSB-1:0];
      end
      // Results become visible together with the DONE pulse.
      if (cap_last && !abort_ev) begin
        pkt_len_q  <= len_q;
        pkt_addr_q <= addr_q;
        addr_err_q <= (addr_q != PORT_ADDR);
        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
      end
    end
  end

`ifdef ROUTER_READER_PARITY_CHECK_EN
  logic [7:0] par_run;
  logic       par_acc;
  logic       par_err_q;

  assign par_acc = rd_q & ~cap_hdr & ~cap_last;

  router_parity_acc u_parity_acc (
    .clock  (clock),
    .resetn (resetn),
    .clr_i  (to_idle),
    .load_i (cap_hdr),
    .acc_i  (par_acc),
    .dat_i  (data_out),
    .par_o  (par_run)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      par_err_q <= 1'b0;
    end else if (cap_last && !abort_ev) begin
      par_err_q <= (data_out != par_run);
    end
  end

  assign parity_err_o = par_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign pkt_done_o = (state_q == DONE);
  assign pkt_len_o  = pkt_len_q;
  assign pkt_addr_o = pkt_addr_q;
  assign addr_err_o = addr_err_q;
  assign abort_o    = abort_q;
  assign pkt_cnt_o  = pkt_cnt_q;

endmodule
